// File: rtl/ws2812_rx.sv
// WS2812 single-wire receiver: decodes GRB pixels MSB first, strobes each with its LED address,
// and flags the frame latch gap. Defining WS2812_RX_FORWARD_EN enables the cascade output DO.
module ws2812_rx #(
    parameter int SYSTEM_CLOCK = 48000000,
    parameter int NUM_LEDS     = 8,
    parameter int T_THRESH_NS  = 600,
    parameter int T_MIN_NS     = 100,
    parameter int T_RESET_US   = 50
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        DI,
    output logic                        pixel_valid,
    output logic [$clog2(NUM_LEDS)-1:0] address,
    output logic [7:0]                  red,
    output logic [7:0]                  green,
    output logic [7:0]                  blue,
    output logic                        frame_done,
    output logic                        frame_error,
    output logic                        DO
);
    localparam int THRESH    = SYSTEM_CLOCK / 1000 * T_THRESH_NS / 1000000;
    localparam int MIN       = SYSTEM_CLOCK / 1000 * T_MIN_NS / 1000000;
    localparam int RESET_CYC = SYSTEM_CLOCK / 1000000 * T_RESET_US;
    localparam int AW        = $clog2(NUM_LEDS);
    localparam int CW        = $clog2(NUM_LEDS + 1);
    localparam int LW        = $clog2(RESET_CYC + 1);

    localparam logic [7:0]    MIN_C    = 8'(MIN);
    localparam logic [7:0]    THRESH_C = 8'(THRESH);
    localparam logic [LW-1:0] RESET_C  = LW'(RESET_CYC);
    localparam logic [CW-1:0] NUM_C    = CW'(NUM_LEDS);

    typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

    logic          meta_q, ds_q, ds_prev_q;
    state_t        state_q, state_d;
    logic          from_low_q, from_low_d;
    logic [7:0]    high_cnt_q, high_cnt_d;
    logic [LW-1:0] low_cnt_q, low_cnt_d;
    logic [4:0]    bit_cnt_q, bit_cnt_d;
    logic [23:0]   shift_q, shift_d;
    logic          pend_q, pend_d;
    logic [CW-1:0] addr_q, addr_d;
    logic          pixel_valid_q, pixel_valid_d;
    logic [AW-1:0] address_q, address_d;
    logic [7:0]    red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic          frame_done_q, frame_done_d;
    logic          frame_error_q, frame_error_d;
    logic          rise;

    assign rise = ds_q & ~ds_prev_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            meta_q        <= 1'b0;
            ds_q          <= 1'b0;
            ds_prev_q     <= 1'b0;
            state_q       <= SYNC;
            from_low_q    <= 1'b0;
            high_cnt_q    <= '0;
            low_cnt_q     <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            pend_q        <= 1'b0;
            addr_q        <= '0;
            pixel_valid_q <= 1'b0;
            address_q     <= '0;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
            frame_done_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            meta_q        <= DI;
            ds_q          <= meta_q;
            ds_prev_q     <= ds_q;
            state_q       <= state_d;
            from_low_q    <= from_low_d;
            high_cnt_q    <= high_cnt_d;
            low_cnt_q     <= low_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            pend_q        <= pend_d;
            addr_q        <= addr_d;
            pixel_valid_q <= pixel_valid_d;
            address_q     <= address_d;
            red_q         <= red_d;
            green_q       <= green_d;
            blue_q        <= blue_d;
            frame_done_q  <= frame_done_d;
            frame_error_q <= frame_error_d;
        end
    end

    // NOTE: every variable gets a default first, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        from_low_d    = from_low_q;
        high_cnt_d    = high_cnt_q;
        low_cnt_d     = low_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        pend_d        = 1'b0;
        addr_d        = addr_q;
        pixel_valid_d = 1'b0;
        address_d     = address_q;
        red_d         = red_q;
        green_d       = green_q;
        blue_d        = blue_q;
        frame_done_d  = 1'b0;
        frame_error_d = 1'b0;

        // A completed pixel strobes one cycle after its last bit; pixels past NUM_LEDS are swallowed.
        if (pend_q && (addr_q < NUM_C)) begin
            pixel_valid_d = 1'b1;
            address_d     = addr_q[AW-1:0];
            green_d       = shift_q[23:16];
            red_d         = shift_q[15:8];
            blue_d        = shift_q[7:0];
            addr_d        = addr_q + 1'b1;
        end

        case (state_q)
            SYNC: begin
                if (ds_q) begin
                    low_cnt_d = '0;
                end else if (low_cnt_q == RESET_C - 1'b1) begin
                    low_cnt_d = RESET_C;
                    state_d   = IDLE;
                end else begin
                    low_cnt_d = low_cnt_q + 1'b1;
                end
            end
            IDLE: begin
                if (rise) begin
                    high_cnt_d = '0;
                    from_low_d = 1'b0;
                    state_d    = HIGH;
                end
            end
            HIGH: begin
                if (ds_q) begin
                    if (high_cnt_q != 8'hFF) high_cnt_d = high_cnt_q + 1'b1;
                end else if (high_cnt_q < MIN_C) begin
                    state_d = from_low_q ? LOW : IDLE;
                end else begin
                    shift_d   = {shift_q[22:0], (high_cnt_q >= THRESH_C)};
                    low_cnt_d = '0;
                    state_d   = LOW;
                    if (bit_cnt_q == 5'd23) begin
                        bit_cnt_d = '0;
                        pend_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            LOW: begin
                if (rise) begin
                    high_cnt_d = '0;
                    from_low_d = 1'b1;
                    state_d    = HIGH;
                end else if (low_cnt_q == RESET_C - 1'b1) begin
                    frame_done_d  = 1'b1;
                    frame_error_d = (bit_cnt_q != 5'd0);
                    bit_cnt_d     = '0;
                    addr_d        = '0;
                    address_d     = '0;
                    low_cnt_d     = RESET_C;
                    state_d       = IDLE;
                end else begin
                    low_cnt_d = low_cnt_q + 1'b1;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    assign pixel_valid = pixel_valid_q;
    assign address     = address_q;
    assign red         = red_q;
    assign green       = green_q;
    assign blue        = blue_q;
    assign frame_done  = frame_done_q;
    assign frame_error = frame_error_q;

`ifdef WS2812_RX_FORWARD_EN
    logic fwd_q, fwd_d, do_q, do_d;

    // Forwarding starts on the rising edge that opens the first pixel beyond our share.
    always_comb begin
        fwd_d = fwd_q;
        if (frame_done_d) begin
            fwd_d = 1'b0;
        end else if (rise && (state_q == IDLE || state_q == LOW) && (addr_q == NUM_C)) begin
            fwd_d = 1'b1;
        end
        do_d = fwd_d & ds_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fwd_q <= 1'b0;
            do_q  <= 1'b0;
        end else begin
            fwd_q <= fwd_d;
            do_q  <= do_d;
        end
    end

    assign DO = do_q;
`else
    assign DO = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812_rx.sv
// Directed self-checking bench for ws2812_rx at default parameters (48 MHz, 8 LEDs).
// DO checks follow the WS2812_RX_FORWARD_EN build option.
module tb_ws2812_rx;
    logic       clk = 1'b0;
    logic       reset;
    logic       DI;
    logic       pixel_valid;
    logic [2:0] address;
    logic [7:0] red, green, blue;
    logic       frame_done, frame_error, DO;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [2:0] a;
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } pix_t;

    pix_t pq[$];
    int   fd_cnt   = 0;
    int   fe_cnt   = 0;
    int   do_rises = 0;
    int   do_bad   = 0;
    int   do_run   = 0;
    logic do_prev  = 1'b0;

    ws2812_rx dut (
        .clk         (clk),
        .reset       (reset),
        .DI          (DI),
        .pixel_valid (pixel_valid),
        .address     (address),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .frame_done  (frame_done),
        .frame_error (frame_error),
        .DO          (DO)
    );

    always #5 clk = ~clk;

    // Collector: strobes are one cycle wide, so record them as they happen.
    always @(negedge clk) begin
        if (pixel_valid) pq.push_back({address, green, red, blue});
        if (frame_done) fd_cnt <= fd_cnt + 1;
        if (frame_error) fe_cnt <= fe_cnt + 1;
        if (DO && !do_prev) do_rises <= do_rises + 1;
        if (DO) begin
            do_run <= do_run + 1;
        end else begin
            if (do_prev && !((do_run >= 18 && do_run <= 20) || (do_run >= 37 && do_run <= 39)))
                do_bad <= do_bad + 1;
            do_run <= 0;
        end
        do_prev <= DO;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        DI = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic glitch);
        int low_len;
        low_len = b ? 22 : 41;
        hold(1'b1, b ? 38 : 19);
        if (glitch) begin
            hold(1'b0, 10);
            hold(1'b1, 3);
            hold(1'b0, low_len - 13);
        end else begin
            hold(1'b0, low_len);
        end
    endtask

    task automatic send_byte(input logic [7:0] v, input logic glitch);
        for (int i = 7; i >= 0; i--) send_bit(v[i], glitch);
    endtask

    task automatic send_pixel(input logic [7:0] g, input logic [7:0] r, input logic [7:0] b,
                              input logic glitch);
        send_byte(g, glitch);
        send_byte(r, glitch);
        send_byte(b, glitch);
    endtask

    task automatic check_pix(input string tag, input int idx, input logic [2:0] a,
                             input logic [7:0] g, input logic [7:0] r, input logic [7:0] b);
        check({tag, "_present"}, pq.size() > idx, 1);
        if (pq.size() > idx) begin
            check({tag, "_addr"}, pq[idx].a, a);
            check({tag, "_green"}, pq[idx].g, g);
            check({tag, "_red"}, pq[idx].r, r);
            check({tag, "_blue"}, pq[idx].b, b);
        end
    endtask

    task automatic send_frame8();
        for (int i = 0; i < 8; i++) send_pixel(8'h40 + 8'(i), 8'(i), 8'hF0 - 8'(i), 1'b0);
    endtask

    task automatic check_frame8(input string tag);
        check({tag, "_count"}, pq.size(), 8);
        for (int i = 0; i < 8; i++)
            check_pix(tag, i, 3'(i), 8'h40 + 8'(i), 8'(i), 8'hF0 - 8'(i));
    endtask

    initial begin
        int fd0, fe0, do0, bad0;

        // Reset state
        reset = 1'b0;
        DI    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pixel_valid", pixel_valid, 0);
        check("rst_address", address, 0);
        check("rst_red", red, 0);
        check("rst_green", green, 0);
        check("rst_blue", blue, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_error", frame_error, 0);
        check("rst_DO", DO, 0);
        reset = 1'b1;

        // Single pixel G=11 R=22 B=33
        hold(1'b0, 2500);
        fd0 = fd_cnt; fe0 = fe_cnt;
        send_pixel(8'h11, 8'h22, 8'h33, 1'b0);
        check("one_count", pq.size(), 1);
        check_pix("one", 0, 3'd0, 8'h11, 8'h22, 8'h33);
        hold(1'b0, 2500);
        check("one_frame_done", fd_cnt - fd0, 1);
        check("one_frame_error", fe_cnt - fe0, 0);
        check("one_hold_red", red, 8'h22);
        pq.delete();

        // Full frame of 8 pixels, red = index
        fd0 = fd_cnt; fe0 = fe_cnt;
        send_frame8();
        hold(1'b0, 2500);
        check_frame8("full");
        check("full_frame_done", fd_cnt - fd0, 1);
        check("full_frame_error", fe_cnt - fe0, 0);
        check("full_addr_reset", address, 0);
        pq.delete();

        // Glitches between every bit are ignored
        fd0 = fd_cnt; fe0 = fe_cnt;
        send_pixel(8'hA5, 8'h5A, 8'hC3, 1'b1);
        hold(1'b0, 2500);
        check("glitch_count", pq.size(), 1);
        check_pix("glitch", 0, 3'd0, 8'hA5, 8'h5A, 8'hC3);
        check("glitch_frame_done", fd_cnt - fd0, 1);
        pq.delete();

        // 12 bits then a latch gap: partial pixel discarded
        fd0 = fd_cnt; fe0 = fe_cnt;
        send_byte(8'hFF, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
        hold(1'b0, 2500);
        check("partial_pixels", pq.size(), 0);
        check("partial_frame_done", fd_cnt - fd0, 1);
        check("partial_frame_error", fe_cnt - fe0, 1);
        pq.delete();

        // 10 pixels: 8 strobes, pixels 8-9 forwarded on DO when enabled
        fd0 = fd_cnt; fe0 = fe_cnt; do0 = do_rises; bad0 = do_bad;
        send_frame8();
        check("fwd_quiet_first192", do_rises - do0, 0);
        send_pixel(8'hF0, 8'h0F, 8'h81, 1'b0);
        send_pixel(8'h3C, 8'hC3, 8'h55, 1'b0);
        hold(1'b0, 2500);
        check_frame8("ten");
        check("ten_frame_done", fd_cnt - fd0, 1);
        check("ten_frame_error", fe_cnt - fe0, 0);
        check("ten_DO_after_frame", DO, 0);
`ifdef WS2812_RX_FORWARD_EN
        check("fwd_pulses", do_rises - do0, 48);
        check("fwd_widths", do_bad - bad0, 0);
`else
        check("fwd_disabled_DO", do_rises - do0, 0);
`endif
        pq.delete();

        // Reset released with DI high, then a pulse train with no latch gap
        fd0 = fd_cnt;
        DI = 1'b1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        hold(1'b1, 50);
        hold(1'b0, 41);
        for (int i = 0; i < 40; i++) send_bit(i[0], 1'b0);
        check("sync_no_pixels", pq.size(), 0);
        check("sync_no_frame_done", fd_cnt - fd0, 0);
        hold(1'b0, 2500);
        send_pixel(8'hC0, 8'hFF, 8'h01, 1'b0);
        hold(1'b0, 2500);
        check("sync_after_count", pq.size(), 1);
        check_pix("sync_after", 0, 3'd0, 8'hC0, 8'hFF, 8'h01);
        check("sync_after_frame_done", fd_cnt - fd0, 1);
        pq.delete();

        // Reset pulse after 30 bits aborts the frame
        send_pixel(8'h12, 8'h34, 8'h56, 1'b0);
        for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b0);
        pq.delete();
        fd0 = fd_cnt; fe0 = fe_cnt;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        check("abort_address", address, 0);
        hold(1'b0, 2500);
        check("abort_no_pixels", pq.size(), 0);
        check("abort_no_frame_done", fd_cnt - fd0, 0);
        send_frame8();
        hold(1'b0, 2500);
        check_frame8("post_abort");
        check("post_abort_frame_done", fd_cnt - fd0, 1);
        check("post_abort_frame_error", fe_cnt - fe0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
